// File: rtl/input_bram_address_generator_pkg.sv
// Shared types and sizing for the input-BRAM address generator.
package input_bram_address_generator_pkg;
   localparam int unsigned CH_W       = 8;
   localparam int unsigned ROW_W      = 8;
   localparam int unsigned COL_W      = 8;
   localparam int unsigned STR_W      = 3;
   localparam int unsigned BRAM_DEPTH = 224 * 224;
   localparam int unsigned AW         = $clog2(BRAM_DEPTH);
   // common width of one nested-counter level (max of ch/row/col widths)
   localparam int unsigned VW         = 8;

   localparam logic MODE_CHW = 1'b0;
   localparam logic MODE_HWC = 1'b1;

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} addr_gen_state_t;

   typedef struct packed {
      logic             mode;
      logic [CH_W-1:0]  num_channel;
      logic [ROW_W-1:0] start_row;
      logic [ROW_W-1:0] end_row;
      logic [COL_W-1:0] num_col;
      logic [STR_W-1:0] stride;
      logic [AW-1:0]    base_addr;
   } cfg_t;
endpackage

// File: rtl/input_bram_address_generator_if.sv
// Config/start and address-stream signals between conv controller, generator and BRAM port.
interface input_bram_address_generator_if;
   import input_bram_address_generator_pkg::*;

   logic             start;
   logic             mode;
   logic [CH_W-1:0]  num_channel;
   logic [ROW_W-1:0] start_row;
   logic [ROW_W-1:0] end_row;
   logic [COL_W-1:0] num_col;
   logic [STR_W-1:0] stride;
   logic [AW-1:0]    base_addr;
   logic             addr_ready;
   logic             addr_valid;
   logic [AW-1:0]    addr;
   logic [CH_W-1:0]  channel;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic             last;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, mode, num_channel, start_row, end_row, num_col, stride, base_addr, addr_ready,
      input  addr_valid, addr, channel, row, col, last, busy, done, err
   );
   modport slave (
      input  start, mode, num_channel, start_row, end_row, num_col, stride, base_addr, addr_ready,
      output addr_valid, addr, channel, row, col, last, busy, done, err
   );
endinterface

// File: rtl/input_bram_address_generator_nested_counter.sv
// Three-level wrap counter: level 0 innermost; tracks level values and a running address
// using add-only updates, with outer-level base registers reloaded on wrap.
module input_bram_address_generator_nested_counter
   import input_bram_address_generator_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                advance,
   input  logic [2:0][VW-1:0]  val_init,
   input  logic [2:0][VW-1:0]  val_step,
   input  logic [2:0][VW-1:0]  val_max,
   input  logic [2:0][AW-1:0]  addr_step,
   input  logic [AW-1:0]       addr_init,
   output logic [2:0][VW-1:0]  val,
   output logic [AW-1:0]       addr,
   output logic                last
);
   logic [2:0][VW-1:0] val_n;
   logic [AW-1:0]      addr_n, base1, base1_n, base2, base2_n;
   logic               last_n, e0, e1, e2;

   // a level is final when one more step would pass its inclusive maximum
   function automatic logic at_end(input logic [VW-1:0] v, input logic [VW-1:0] s,
                                   input logic [VW-1:0] m);
      return ((VW+1)'(v) + (VW+1)'(s)) > (VW+1)'(m);
   endfunction

   function automatic logic [VW-1:0] add_v(input logic [VW-1:0] a, input logic [VW-1:0] b);
      return VW'((VW+1)'(a) + (VW+1)'(b));
   endfunction

   function automatic logic [AW-1:0] add_a(input logic [AW-1:0] a, input logic [AW-1:0] b);
      return AW'((AW+1)'(a) + (AW+1)'(b));
   endfunction

   always_comb begin
      val_n   = val;
      addr_n  = addr;
      base1_n = base1;
      base2_n = base2;
      last_n  = last;
      e0      = at_end(val[0], val_step[0], val_max[0]);
      e1      = at_end(val[1], val_step[1], val_max[1]);
      e2      = at_end(val[2], val_step[2], val_max[2]);
      if (load) begin
         val_n   = val_init;
         addr_n  = addr_init;
         base1_n = addr_init;
         base2_n = addr_init;
      end else if (advance) begin
         if (!e0) begin
            val_n[0] = add_v(val[0], val_step[0]);
            addr_n   = add_a(addr, addr_step[0]);
         end else if (!e1) begin
            val_n[0] = val_init[0];
            val_n[1] = add_v(val[1], val_step[1]);
            base1_n  = add_a(base1, addr_step[1]);
            addr_n   = base1_n;
         end else if (!e2) begin
            val_n[0] = val_init[0];
            val_n[1] = val_init[1];
            val_n[2] = add_v(val[2], val_step[2]);
            base2_n  = add_a(base2, addr_step[2]);
            base1_n  = base2_n;
            addr_n   = base2_n;
         end
      end
      if (load || advance) begin
         last_n = !(advance && e0 && e1 && e2) &&
                  at_end(val_n[0], val_step[0], val_max[0]) &&
                  at_end(val_n[1], val_step[1], val_max[1]) &&
                  at_end(val_n[2], val_step[2], val_max[2]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val   <= '0;
         addr  <= '0;
         base1 <= '0;
         base2 <= '0;
         last  <= 1'b0;
      end else begin
         val   <= val_n;
         addr  <= addr_n;
         base1 <= base1_n;
         base2 <= base2_n;
         last  <= last_n;
      end
   end
endmodule

// File: rtl/input_bram_address_generator.sv
// Streams input-BRAM read addresses for a row batch in CHW or HWC order with stride and base offset.
module input_bram_address_generator
   import input_bram_address_generator_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input_bram_address_generator_if.slave bus
);
   addr_gen_state_t    state;
   cfg_t               cfg;
   logic [2:0][AW-1:0] astep;
   logic               addr_valid, busy, done, err;
   logic               load, advance, bad_cfg;
   logic [2:0][VW-1:0] vinit, vstep, vmax, val;
   logic [AW-1:0]      addr, rows, plane, sw, sc, swc;
   logic               last;

   assign load    = (state == RUN) && !addr_valid;
   assign advance = addr_valid && bus.addr_ready;
   assign bad_cfg = (bus.num_channel == '0) || (bus.num_col == '0) || (bus.stride == '0) ||
                    (bus.end_row < bus.start_row);

   // level mapping: CHW = col/row/ch, HWC = ch/col/row (innermost first)
   always_comb begin
      vinit = '0;
      vstep = '0;
      vmax  = '0;
      if (cfg.mode == MODE_CHW) begin
         vinit[1] = VW'(cfg.start_row);
         vstep[0] = VW'(cfg.stride);
         vstep[1] = VW'(cfg.stride);
         vstep[2] = VW'(1);
         vmax[0]  = VW'(cfg.num_col) - VW'(1);
         vmax[1]  = VW'(cfg.end_row);
         vmax[2]  = VW'(cfg.num_channel) - VW'(1);
      end else begin
         vinit[2] = VW'(cfg.start_row);
         vstep[0] = VW'(1);
         vstep[1] = VW'(cfg.stride);
         vstep[2] = VW'(cfg.stride);
         vmax[0]  = VW'(cfg.num_channel) - VW'(1);
         vmax[1]  = VW'(cfg.num_col) - VW'(1);
         vmax[2]  = VW'(cfg.end_row);
      end
   end

   // stride pre-multiplies, registered once in SETUP
   always_comb begin
      rows  = AW'((AW+1)'(cfg.end_row) - (AW+1)'(cfg.start_row) + (AW+1)'(1));
      plane = AW'((AW+1)'(rows) * (AW+1)'(cfg.num_col));
      sw    = AW'((AW+1)'(cfg.stride) * (AW+1)'(cfg.num_col));
      sc    = AW'((AW+1)'(cfg.stride) * (AW+1)'(cfg.num_channel));
      swc   = AW'((AW+1)'(sw) * (AW+1)'(cfg.num_channel));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cfg        <= '0;
         astep      <= '0;
         addr_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bad_cfg) begin
                     err <= 1'b1;
                  end else begin
                     cfg   <= '{mode: bus.mode, num_channel: bus.num_channel,
                                start_row: bus.start_row, end_row: bus.end_row,
                                num_col: bus.num_col, stride: bus.stride,
                                base_addr: bus.base_addr};
                     busy  <= 1'b1;
                     state <= SETUP;
                  end
               end
            end
            SETUP: begin
               if (cfg.mode == MODE_CHW) astep <= {plane, sw, AW'(cfg.stride)};
               else                      astep <= {swc, sc, AW'(1)};
               state <= RUN;
            end
            RUN: begin
               if (load) begin
                  addr_valid <= 1'b1;
               end else if (advance && last) begin
                  addr_valid <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   input_bram_address_generator_nested_counter u_counter (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .advance   (advance),
      .val_init  (vinit),
      .val_step  (vstep),
      .val_max   (vmax),
      .addr_step (astep),
      .addr_init (cfg.base_addr),
      .val       (val),
      .addr      (addr),
      .last      (last)
   );

   assign bus.addr_valid = addr_valid;
   assign bus.addr       = addr;
   assign bus.last       = last;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.err        = err;
   assign bus.channel    = (cfg.mode == MODE_HWC) ? CH_W'(val[0])  : CH_W'(val[2]);
   assign bus.row        = (cfg.mode == MODE_HWC) ? ROW_W'(val[2]) : ROW_W'(val[1]);
   assign bus.col        = (cfg.mode == MODE_HWC) ? COL_W'(val[1]) : COL_W'(val[0]);
endmodule

// File: tb/tb_input_bram_address_generator.sv
// Self-checking bench: directed and random jobs against a nested-loop reference model.
module tb_input_bram_address_generator;
   import input_bram_address_generator_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   input_bram_address_generator_if bus();
   input_bram_address_generator dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct { int addr; int ch; int row; int col; bit last; } beat_t;
   typedef struct { bit mode; int c; int sr; int er; int w; int s; int base; } job_t;
   beat_t exp_q[$];

   // reference: plain nested loops over the visited index space
   function automatic void build(input job_t j);
      int r = j.er - j.sr + 1;
      int n;
      beat_t b;
      exp_q.delete();
      if (j.mode == 1'b0) begin
         for (int ch = 0; ch < j.c; ch++)
            for (int row = j.sr; row <= j.er; row += j.s)
               for (int col = 0; col < j.w; col += j.s) begin
                  b = '{(j.base + ch*r*j.w + (row-j.sr)*j.w + col) & 32'hFFFF, ch, row, col, 1'b0};
                  exp_q.push_back(b);
               end
      end else begin
         for (int row = j.sr; row <= j.er; row += j.s)
            for (int col = 0; col < j.w; col += j.s)
               for (int ch = 0; ch < j.c; ch++) begin
                  b = '{(j.base + ((row-j.sr)*j.w + col)*j.c + ch) & 32'hFFFF, ch, row, col, 1'b0};
                  exp_q.push_back(b);
               end
      end
      n = exp_q.size();
      b = exp_q[n-1];
      b.last = 1'b1;
      exp_q[n-1] = b;
   endfunction

   task automatic drive_cfg(input job_t j);
      bus.mode        = j.mode;
      bus.num_channel = CH_W'(j.c);
      bus.start_row   = ROW_W'(j.sr);
      bus.end_row     = ROW_W'(j.er);
      bus.num_col     = COL_W'(j.w);
      bus.stride      = STR_W'(j.s);
      bus.base_addr   = AW'(j.base);
   endtask

   task automatic start_job(input job_t j);
      drive_cfg(j);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // rdy_mode: 0 always ready, 1 toggling, 2 random
   task automatic run_job(input job_t j, input int rdy_mode, input bit poke, input string name);
      int idx = 0;
      int cyc = 0;
      int first = -1;
      int budget;
      bit stalled = 1'b0;
      bit rdy;
      logic [AW-1:0]    h_addr;
      logic [CH_W-1:0]  h_ch;
      logic [ROW_W-1:0] h_row;
      logic [COL_W-1:0] h_col;
      logic             h_last;
      beat_t e;
      job_t other;
      build(j);
      budget = exp_q.size() * 4 + 20;
      bus.addr_ready = 1'b0;
      start_job(j);
      checks++;
      if (bus.busy !== 1'b1 || bus.addr_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s busy_after_start: busy=%b valid=%b, required busy=1 valid=0",
                  name, bus.busy, bus.addr_valid);
      end
      while (idx < exp_q.size() && cyc < budget) begin
         if (stalled) begin
            checks++;
            if (bus.addr_valid !== 1'b1 || bus.addr !== h_addr || bus.channel !== h_ch ||
                bus.row !== h_row || bus.col !== h_col || bus.last !== h_last) begin
               failures++;
               $display("FAIL %s hold beat %0d: valid=%b addr=%0d last=%b, required valid=1 addr=%0d last=%b",
                        name, idx, bus.addr_valid, bus.addr, bus.last, h_addr, h_last);
            end
         end
         if (bus.addr_valid === 1'b1 && first < 0) begin
            first = cyc;
            checks++;
            if (first != 2) begin
               failures++;
               $display("FAIL %s first_valid_latency: got %0d cycles, required 2", name, first);
            end
         end
         if (poke && cyc == 5) begin
            other = j;
            other.c = j.c + 1;
            other.mode = !j.mode;
            drive_cfg(other);
            bus.start = 1'b1;
         end else if (poke && cyc == 6) begin
            drive_cfg(j);
            bus.start = 1'b0;
         end
         case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         bus.addr_ready = rdy;
         stalled = 1'b0;
         if (bus.addr_valid === 1'b1) begin
            if (rdy) begin
               e = exp_q[idx];
               checks++;
               if (bus.addr !== AW'(e.addr) || bus.channel !== CH_W'(e.ch) ||
                   bus.row !== ROW_W'(e.row) || bus.col !== COL_W'(e.col) || bus.last !== e.last) begin
                  failures++;
                  $display("FAIL %s beat %0d: addr=%0d ch=%0d row=%0d col=%0d last=%b, required addr=%0d ch=%0d row=%0d col=%0d last=%b",
                           name, idx, bus.addr, bus.channel, bus.row, bus.col, bus.last,
                           e.addr, e.ch, e.row, e.col, e.last);
               end
               idx++;
            end else begin
               stalled = 1'b1;
               h_addr = bus.addr; h_ch = bus.channel; h_row = bus.row;
               h_col = bus.col; h_last = bus.last;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.addr_ready = 1'b0;
      if (idx < exp_q.size()) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: %0d beats seen, required %0d", name, idx, exp_q.size());
      end
      checks++;
      if (bus.addr_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s end_of_job: valid=%b done=%b busy=%b, required valid=0 done=1 busy=0",
                  name, bus.addr_valid, bus.done, bus.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.addr_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s done_pulse_width: done=%b valid=%b, required 0 0", name, bus.done, bus.addr_valid);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (bus.addr_valid !== 1'b0 || bus.addr !== '0 || bus.channel !== '0 || bus.row !== '0 ||
          bus.col !== '0 || bus.last !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.err !== 1'b0) begin
         failures++;
         $display("FAIL %s outputs_zero: valid=%b addr=%0d ch=%0d row=%0d col=%0d last=%b busy=%b done=%b err=%b, required all 0",
                  name, bus.addr_valid, bus.addr, bus.channel, bus.row, bus.col, bus.last,
                  bus.busy, bus.done, bus.err);
      end
   endtask

   localparam job_t JOB1 = '{1'b0, 2, 4, 5, 3, 1, 0};

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.addr_ready = 1'b0;
      drive_cfg(JOB1);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check_all_zero("after_reset_release");
   endtask

   task automatic test_chw();
      run_job(JOB1, 0, 1'b0, "chw");
   endtask

   task automatic test_hwc();
      job_t j = JOB1;
      j.mode = 1'b1;
      run_job(j, 0, 1'b0, "hwc");
   endtask

   task automatic test_stride();
      run_job('{1'b0, 1, 0, 3, 4, 2, 100}, 0, 1'b0, "stride_chw");
      run_job('{1'b1, 3, 2, 7, 5, 3, 65530}, 0, 1'b0, "stride_hwc_wrap");
   endtask

   task automatic test_backpressure();
      run_job(JOB1, 1, 1'b0, "backpressure_toggle");
      run_job('{1'b1, 2, 1, 3, 5, 2, 7}, 2, 1'b0, "backpressure_random");
   endtask

   task automatic test_single_beat();
      run_job('{1'b0, 1, 7, 7, 1, 3, 42}, 0, 1'b0, "single_beat_chw");
      run_job('{1'b1, 1, 9, 9, 1, 1, 5}, 1, 1'b0, "single_beat_hwc");
   endtask

   task automatic test_bad_config();
      job_t bad[4];
      bad[0] = '{1'b0, 1, 5, 2, 3, 1, 0};
      bad[1] = '{1'b0, 0, 0, 1, 3, 1, 0};
      bad[2] = '{1'b1, 2, 0, 1, 0, 1, 0};
      bad[3] = '{1'b1, 2, 0, 1, 3, 0, 0};
      bus.addr_ready = 1'b1;
      foreach (bad[k]) begin
         start_job(bad[k]);
         checks++;
         if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_config_%0d err_pulse: err=%b busy=%b valid=%b, required err=1 busy=0 valid=0",
                     k, bus.err, bus.busy, bus.addr_valid);
         end
         repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (bus.err !== 1'b0 || bus.addr_valid !== 1'b0 || bus.busy !== 1'b0) begin
               failures++;
               $display("FAIL bad_config_%0d idle_after: err=%b valid=%b busy=%b, required 0 0 0",
                        k, bus.err, bus.addr_valid, bus.busy);
            end
         end
      end
      bus.addr_ready = 1'b0;
      run_job(JOB1, 0, 1'b1, "start_during_run");
   endtask

   task automatic test_reset_midstream();
      start_job(JOB1);
      bus.addr_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (bus.addr_valid !== 1'b1 || bus.addr !== AW'(4)) begin
         failures++;
         $display("FAIL reset_mid fifth_beat: valid=%b addr=%0d, required valid=1 addr=4",
                  bus.addr_valid, bus.addr);
      end
      rst = 1'b1;
      #1;
      check_all_zero("reset_mid_async");
      @(posedge clk); #1;
      rst = 1'b0;
      bus.addr_ready = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         checks++;
         if (bus.done !== 1'b0 || bus.addr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid no_done: done=%b valid=%b busy=%b, required 0 0 0",
                     bus.done, bus.addr_valid, bus.busy);
         end
      end
      run_job(JOB1, 0, 1'b0, "restart_after_reset");
   endtask

   task automatic test_random();
      job_t j;
      for (int n = 0; n < 8; n++) begin
         j.mode = 1'($urandom_range(0, 1));
         j.c    = int'($urandom_range(1, 4));
         j.sr   = int'($urandom_range(0, 20));
         j.er   = j.sr + int'($urandom_range(0, 4));
         j.w    = int'($urandom_range(1, 7));
         j.s    = int'($urandom_range(1, 3));
         j.base = int'($urandom_range(0, 65535));
         run_job(j, 2, 1'b0, $sformatf("random_%0d", n));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_chw();
      test_hwc();
      test_stride();
      test_backpressure();
      test_single_beat();
      test_bad_config();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
